uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
- Parametrised serial UART transmitter and the sequential successor to the combinational frame-bit generator.
- Accepts one data word per valid/ready handshake and serialises it as a frame: start bit, DATA_BITS data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- The bit rate is set by a clock-divider parameter.
- Sits between the switch/register front end and the board TXD pin.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 434, clk cycles per bit time (50 MHz / 115200); must be >= 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  DATA_BITS  word to send; bit 0 is sent first.
- tx_valid  input  1  tx_data and the config inputs are valid.
- tx_ready  output  1  block can accept a word this cycle.
- parity_en  input  1  1 = insert parity bit; 0 = no parity bit.
- parity_odd  input  1  parity sense: 0 = even, 1 = odd; ignored when parity_en=0.
- two_stop  input  1  0 = one stop bit; 1 = two stop bits.
- txd  output  1  serial line; idles high; registered output.
- busy  output  1  high while a frame is on the line (any state except IDLE).

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, txd=1, tx_ready=1, busy=0, all counters=0. Any frame in progress is aborted; txd is 1 from the first reset edge onward.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Acceptance: on an edge with tx_valid && tx_ready, the block latches tx_data, parity_en, parity_odd and two_stop into shadow registers. Input changes after acceptance have no effect on the frame.
- Latency: txd=0 (start bit) from the first edge after acceptance. tx_ready=0 and busy=1 from the same edge.
- tx_ready is 1 only in IDLE. tx_valid while not ready is ignored; there is no queueing.
- Bit timing: each bit drives txd for exactly CLKS_PER_BIT cycles. A baud counter counts 0..CLKS_PER_BIT-1 and produces bit_end on the terminal count. The counter restarts at 0 on every state entry.
- START -> DATA on bit_end.
- DATA: txd = shadow[bit_idx], with bit_idx counting 0..DATA_BITS-1. On bit_end at the last index, go to PARITY if parity_en, otherwise go to STOP.
- PARITY: txd = XOR of all shadow data bits, XOR parity_odd. The total count of 1s over data plus parity is even (even mode) or odd (odd mode). PARITY -> STOP on bit_end.
- STOP: txd=1 for 1 bit time, or 2 bit times if two_stop. On the final bit_end, go to IDLE.
- Frame length is CLKS_PER_BIT*(1+DATA_BITS+parity_en+1+two_stop) cycles, measured from the start-bit edge to the IDLE entry edge.
- Back-to-back: a word presented continuously is accepted in the first IDLE cycle. This gives exactly one clk of txd=1 idle between the last stop bit and the next start bit.
- Corner cases:
  - rst asserted coincident with tx_valid: reset wins and the word is not accepted.
  - tx_data all-zeros and all-ones are legal.
  - The baud counter width is $clog2(CLKS_PER_BIT) and it must never exceed CLKS_PER_BIT-1.
- txd must be glitch-free: it is driven directly from a flop, with no combinational path to the pin.

Decomposition:
- Shared header uart_defs.vh holds:
  - FSM state encodings: ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP.
  - Parity sense constants: PAR_EVEN=0, PAR_ODD=1.
  - Default CLKS_PER_BIT for 50 MHz / 115200.
- A future uart_rx also uses this header.
- One sub-module, baud_tick_gen:
  - Parameter CLKS_PER_BIT.
  - Ports clk, rst, clear, tick.
  - Counts while not cleared and pulses tick for one cycle at the terminal count.
- The FSM, shift/index logic and parity logic stay in uart_tx_framer.

Test Plan:
- Use CLKS_PER_BIT=4 and DATA_BITS=8 unless stated.
- 8N1: send 0xA5 with parity_en=0 and two_stop=0.
  - txd sequence per 4-clk bit: 0,1,0,1,0,0,1,0,1,1.
  - Frame is 40 clks; tx_ready returns 1 on the 41st edge.
- 8E1 and 8O1: send 0x07 (three 1s). Parity bit = 1 in even mode and 0 in odd mode. Send 0x00: parity bit = 0 (even) and 1 (odd).
- 8N2 plus config freeze: send 0xFF with two_stop=1, then toggle two_stop, parity_en and tx_data mid-frame. The frame is unchanged: 8 data bits of 1 and a stop high for 8 clks; total 44 clks.
- Back-to-back: hold tx_valid=1 with 0x3C then 0xC3. Exactly 1 clk of txd=1 between frames. Both decode correctly and exactly two handshakes occur.
- Reset mid-frame: assert rst during data bit 3. Next edge: txd=1, tx_ready=1, busy=0. A new word of 0x55 after reset transmits a clean full frame.
- DATA_BITS=5 with CLKS_PER_BIT=2: send 0x1F with parity_en=1, parity_odd=0. Sequence is 0,1,1,1,1,1,1,1. Frame is 16 clks.

Source files
------------

// File: rtl/uart_tx_framer_pkg.sv
// Shared UART definitions: FSM state encodings, parity sense and default bit timing.
// A future receiver imports the same package.
package uart_tx_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // 50 MHz system clock, 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_tx_framer_baud_tick_gen.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while not cleared and pulses tick
// for one cycle on the terminal count.
module baud_tick_gen
  import uart_tx_framer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Wrapping at LAST means a state that lasts several bits restarts cleanly
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_BITS data bits LSB first, optional parity,
// one or two stop bits. txd is driven straight from a flop.
module uart_tx_framer
  import uart_tx_framer_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic                 txd,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_t            state, state_n;
  logic [DATA_BITS-1:0] shadow, shadow_n;
  logic                 sh_pe, sh_pe_n;
  logic                 sh_po, sh_po_n;
  logic                 sh_ts, sh_ts_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic                 stop_cnt, stop_cnt_n;
  logic                 txd_n;
  logic                 accept;
  logic                 bit_end;
  logic                 baud_clear;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic sense);
    return (^d) ^ (sense == PAR_ODD);
  endfunction

  assign tx_ready   = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign accept     = tx_valid && tx_ready;
  assign baud_clear = (state == ST_IDLE);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (bit_end)
  );

  always_comb begin
    state_n    = state;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    shadow_n   = shadow;
    sh_pe_n    = sh_pe;
    sh_po_n    = sh_po;
    sh_ts_n    = sh_ts;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n    = ST_START;
          shadow_n   = tx_data;
          sh_pe_n    = parity_en;
          sh_po_n    = parity_odd;
          sh_ts_n    = two_stop;
          bit_idx_n  = '0;
          stop_cnt_n = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == LAST_IDX) begin
            state_n = sh_pe ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_n = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (sh_ts && !stop_cnt) begin
            stop_cnt_n = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Line level is decoded from the next state so the flop shows the new bit on the entry edge
  always_comb begin
    txd_n = 1'b1;
    case (state_n)
      ST_START:  txd_n = 1'b0;
      ST_DATA:   txd_n = shadow_n[bit_idx_n];
      ST_PARITY: txd_n = parity_bit(shadow_n, sh_po_n);
      default:   txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      txd      <= 1'b1;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      state    <= state_n;
      txd      <= txd_n;
      bit_idx  <= bit_idx_n;
      stop_cnt <= stop_cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    shadow <= shadow_n;
    sh_pe  <= sh_pe_n;
    sh_po  <= sh_po_n;
    sh_ts  <= sh_ts_n;
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Randomized and directed bench for uart_tx_framer against a per-clock line-level model.
// Two instances: 8 data bits at 4 clk/bit and 5 data bits at 2 clk/bit.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tdata;
  logic       tv, pe, po, ts;
  logic       sel;
  logic       va, vb;
  logic       a_txd, a_ready, a_busy;
  logic       b_txd, b_ready, b_busy;
  logic       txd_s, ready_s, busy_s;

  int n_vec = 0;
  int n_err = 0;
  int hs    = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  assign va      = tv && !sel;
  assign vb      = tv && sel;
  assign txd_s   = sel ? b_txd   : a_txd;
  assign ready_s = sel ? b_ready : a_ready;
  assign busy_s  = sel ? b_busy  : a_busy;

  uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(4)) u_dut8 (
    .clk(clk), .rst(rst), .tx_data(tdata), .tx_valid(va), .tx_ready(a_ready),
    .parity_en(pe), .parity_odd(po), .two_stop(ts), .txd(a_txd), .busy(a_busy)
  );

  uart_tx_framer #(.DATA_BITS(5), .CLKS_PER_BIT(2)) u_dut5 (
    .clk(clk), .rst(rst), .tx_data(tdata[4:0]), .tx_valid(vb), .tx_ready(b_ready),
    .parity_en(pe), .parity_odd(po), .two_stop(ts), .txd(b_txd), .busy(b_busy)
  );

  always @(posedge clk) if (!rst && tv && ready_s) hs++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame as a list of bit levels, each repeated for one bit time
  task automatic build(input logic [7:0] d, input logic p_en, input logic p_odd, input logic two);
    int nb;
    int cpb;
    int ones;
    bit bits[$];
    nb   = sel ? 5 : 8;
    cpb  = sel ? 2 : 4;
    ones = 0;
    exp_q.delete();
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (p_en) bits.push_back((ones % 2 == 1) ^ p_odd);
    bits.push_back(1'b1);
    if (two) bits.push_back(1'b1);
    foreach (bits[k]) for (int c = 0; c < cpb; c++) exp_q.push_back(bits[k]);
  endtask

  task automatic accept_word(input logic [7:0] d, input logic p_en, input logic p_odd,
                             input logic two, input bit hold);
    int guard;
    @(negedge clk);
    tdata = d; pe = p_en; po = p_odd; ts = two; tv = 1'b1;
    guard = 0;
    while (!ready_s && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", guard < 200, 1);
    @(posedge clk);
    #1;
    if (!hold) tv = 1'b0;
    build(d, p_en, p_odd, two);
  endtask

  task automatic check_frame(input string tag);
    foreach (exp_q[i]) begin
      @(negedge clk);
      check({tag, "_txd"}, txd_s, exp_q[i]);
      check({tag, "_busy"}, busy_s, 1);
      check({tag, "_ready"}, ready_s, 0);
    end
    @(negedge clk);
    check({tag, "_end_ready"}, ready_s, 1);
    check({tag, "_end_busy"}, busy_s, 0);
    check({tag, "_end_txd"}, txd_s, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    logic [7:0] d;
    rst = 1'b1; tv = 1'b0; tdata = '0; pe = 0; po = 0; ts = 0; sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_txd", txd_s, 1);
    check("rst_ready", ready_s, 1);
    check("rst_busy", busy_s, 0);

    // Reset coincident with valid: word must not be taken
    hs0 = hs;
    tv = 1'b1; tdata = 8'h81;
    @(negedge clk);
    check("rstvalid_busy", busy_s, 0);
    check("rstvalid_txd", txd_s, 1);
    check("rstvalid_hs", hs - hs0, 0);
    tv = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", busy_s, 0);

    accept_word(8'hA5, 0, 0, 0, 0); check_frame("8n1_a5");
    accept_word(8'h07, 1, 0, 0, 0); check_frame("8e1_07");
    accept_word(8'h07, 1, 1, 0, 0); check_frame("8o1_07");
    accept_word(8'h00, 1, 0, 0, 0); check_frame("8e1_00");
    accept_word(8'h00, 1, 1, 0, 0); check_frame("8o1_00");

    // Config freeze: inputs change right after acceptance
    accept_word(8'hFF, 0, 0, 1, 0);
    tdata = 8'h12; pe = 1'b1; ts = 1'b0; po = 1'b1;
    check_frame("8n2_ff");

    // Back-to-back with valid held high
    hs0 = hs;
    accept_word(8'h3C, 0, 0, 0, 1);
    tdata = 8'hC3;
    check_frame("b2b_3c");
    build(8'hC3, 0, 0, 0);
    @(posedge clk);
    #1 tv = 1'b0;
    check_frame("b2b_c3");
    repeat (3) @(negedge clk);
    check("b2b_hs", hs - hs0, 2);

    // Reset during data bit 3
    accept_word(8'hA5, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check("prerst_txd", txd_s, exp_q[i]);
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_txd", txd_s, 1);
    check("midrst_ready", ready_s, 1);
    check("midrst_busy", busy_s, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("postrst_txd", txd_s, 1);
    end
    accept_word(8'h55, 0, 0, 0, 0); check_frame("postrst_55");

    for (int n = 0; n < 25; n++) begin
      d = 8'($urandom);
      accept_word(d, 1'($urandom), 1'($urandom), 1'($urandom), 0);
      check_frame("rand8");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // 5-bit instance
    @(negedge clk);
    sel = 1'b1;
    accept_word(8'h1F, 1, 0, 0, 0); check_frame("5e1_1f");
    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom) & 8'h1F;
      accept_word(d, 1'($urandom), 1'($urandom), 1'($urandom), 0);
      check_frame("rand5");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
